// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised register file.
//   RF_WIDTH    default data bits per register
//   RF_DEPTH    default number of registers
//   RF_ZERO_REG default hardwired-zero register index
//   rf_addr_t   register index at the default depth
//   rf_data_t   register word at the default width
package regfile_pkg;

  localparam int RF_WIDTH    = 64;
  localparam int RF_DEPTH    = 32;
  localparam int RF_ZERO_REG = 31;

  typedef logic [$clog2(RF_DEPTH)-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0]         rf_data_t;

endpackage

// File: rtl/param_regfile_rf_read_port.sv
// One combinational read port of param_regfile.
//   reset          high suppresses write-to-read forwarding
//   regs           flattened register array, regs[i] is register i
//   ReadRegister   read address
//   WriteRegister  write addresses of all write ports
//   WriteData      write data of all write ports
//   RegWrite       per-write-port enable
//   ReadData       selected word (array, forwarded write data or zero)
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                           reset,
  input  logic [DEPTH-1:0][WIDTH-1:0]    regs,
  input  logic [AW-1:0]                  ReadRegister,
  input  logic [NUM_WR-1:0][AW-1:0]      WriteRegister,
  input  logic [NUM_WR-1:0][WIDTH-1:0]   WriteData,
  input  logic [NUM_WR-1:0]              RegWrite,
  output logic [WIDTH-1:0]               ReadData
);

  localparam bit          HAS_ZERO  = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = HAS_ZERO ? AW'(ZERO_REG) : '0;

  logic bypassOn;
  assign bypassOn = (BYPASS != 0) && !reset;

  // Later write ports override earlier ones, so port 1 wins a double match.
  // The zero-register override is applied last so it beats forwarding.
  always_comb begin
    ReadData = regs[ReadRegister];
    if (bypassOn) begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (RegWrite[w] && (WriteRegister[w] == ReadRegister))
          ReadData = WriteData[w];
      end
    end
    if (HAS_ZERO && (ReadRegister == ZERO_ADDR))
      ReadData = '0;
  end

endmodule

// File: rtl/param_regfile.sv
// Parametrised multi-port register file for the pipelined CPU.
//   clk            clock, state updates on rising edge
//   reset          synchronous active-high, clears every register
//   ReadRegister   [NUM_RD] read addresses
//   ReadData       [NUM_RD] combinational read data
//   WriteRegister  [NUM_WR] write addresses
//   WriteData      [NUM_WR] write data
//   RegWrite       [NUM_WR] per-port write enable (port 1 wins collisions)
module param_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD-1:0][AW-1:0]     ReadRegister,
  output logic [NUM_RD-1:0][WIDTH-1:0]  ReadData,
  input  logic [NUM_WR-1:0][AW-1:0]     WriteRegister,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  WriteData,
  input  logic [NUM_WR-1:0]             RegWrite
);

  localparam bit HAS_ZERO = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
    $error("param_regfile: DEPTH must be a power of 2 and >= 2");
  end
  if ((NUM_RD < 1) || (NUM_RD > 4)) begin : gBadRd
    $error("param_regfile: NUM_RD must be 1..4");
  end
  if ((NUM_WR < 1) || (NUM_WR > 2)) begin : gBadWr
    $error("param_regfile: NUM_WR must be 1..2");
  end
  if ((ZERO_REG < 0) || (ZERO_REG > DEPTH)) begin : gBadZero
    $error("param_regfile: ZERO_REG must be 0..DEPTH");
  end

  logic [DEPTH-1:0][WIDTH-1:0] regs;

  // Per-register write decode; scanning ports in ascending order lets port 1
  // overwrite port 0's selection on an address collision.
  for (genvar r = 0; r < DEPTH; r++) begin : gReg
    localparam bit WRITABLE = !(HAS_ZERO && (r == ZERO_REG));

    logic             hit;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] q;

    always_comb begin
      hit = 1'b0;
      nxt = q;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (RegWrite[w] && (WriteRegister[w] == AW'(r))) begin
          hit = 1'b1;
          nxt = WriteData[w];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset)
        q <= '0;
      else if (hit && WRITABLE)
        q <= nxt;
    end

    assign regs[r] = q;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : gRd
    rf_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) uPort (
      .reset         (reset),
      .regs          (regs),
      .ReadRegister  (ReadRegister[p]),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite),
      .ReadData      (ReadData[p])
    );
  end

endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench for param_regfile: four configurations share one
// stimulus stream and are compared every cycle against an array model.
module tb_param_regfile;

  localparam logic [63:0] K = 64'h0000010204080001;

  // Configurations: u0 default, u1 2 write ports no bypass,
  // u2 2 write ports with bypass, u3 32x16 3 read ports no zero register.
  localparam int DEP[4]  = '{32, 32, 32, 16};
  localparam int ZR[4]   = '{31, 31, 31, 16};
  localparam int BYP[4]  = '{1, 0, 1, 1};
  localparam int NWR[4]  = '{1, 2, 2, 1};
  localparam int NRD[4]  = '{2, 2, 2, 3};
  localparam logic [63:0] MASK[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                      64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0][4:0]  ra;
  logic [1:0][4:0]  wa;
  logic [1:0][63:0] wd;
  logic [1:0]       we;

  logic [1:0][63:0] rdU0, rdU1, rdU2;
  logic [2:0][31:0] rdU3;

  int errors = 0;
  int checks = 0;
  bit valid  = 0;
  logic [63:0] mem [4][32];

  always #5 clk = ~clk;

  param_regfile uDut0 (
    .clk(clk), .reset(rst), .ReadRegister(ra[1:0]), .ReadData(rdU0),
    .WriteRegister(wa[0]), .WriteData(wd[0]), .RegWrite(we[0])
  );

  param_regfile #(.NUM_WR(2), .BYPASS(0)) uDut1 (
    .clk(clk), .reset(rst), .ReadRegister(ra[1:0]), .ReadData(rdU1),
    .WriteRegister(wa), .WriteData(wd), .RegWrite(we)
  );

  param_regfile #(.NUM_WR(2), .BYPASS(1)) uDut2 (
    .clk(clk), .reset(rst), .ReadRegister(ra[1:0]), .ReadData(rdU2),
    .WriteRegister(wa), .WriteData(wd), .RegWrite(we)
  );

  param_regfile #(.WIDTH(32), .DEPTH(16), .NUM_RD(3), .ZERO_REG(16)) uDut3 (
    .clk(clk), .reset(rst), .ReadRegister({ra[2][3:0], ra[1][3:0], ra[0][3:0]}),
    .ReadData(rdU3), .WriteRegister(wa[0][3:0]), .WriteData(wd[0][31:0]),
    .RegWrite(we[0])
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] actual(input int i, input int p);
    case (i)
      0:       return rdU0[p];
      1:       return rdU1[p];
      2:       return rdU2[p];
      default: return {32'h0, rdU3[p]};
    endcase
  endfunction

  // Expected read value from the architectural rules.
  function automatic logic [63:0] mRead(input int i, input logic [4:0] a);
    int ad;
    ad = int'(a) & (DEP[i] - 1);
    if (ad == ZR[i]) return '0;
    if (BYP[i] != 0 && !rst) begin
      for (int w = NWR[i] - 1; w >= 0; w--) begin
        if (we[w] && ((int'(wa[w]) & (DEP[i] - 1)) == ad))
          return wd[w] & MASK[i];
      end
    end
    return mem[i][ad];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        for (int a = 0; a < 32; a++)
          mem[i][a] = '0;
      valid = 1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int w = 0; w < NWR[i]; w++) begin
          if (we[w]) begin
            int ad;
            ad = int'(wa[w]) & (DEP[i] - 1);
            if (ad != ZR[i]) mem[i][ad] = wd[w] & MASK[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      for (int i = 0; i < 4; i++)
        for (int p = 0; p < NRD[i]; p++)
          check($sformatf("model u%0d rd%0d", i, p), actual(i, p), mRead(i, ra[p]));
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ra = '0; wa = '0; wd = '0; we = '0;
    nextCycle();
    nextCycle();
    rst = 1'b0;

    // Zero register ignores writes and reads 0 even when forwarded.
    ra[0] = 5'd31; ra[1] = 5'd0; wa[0] = 5'd31; wd[0] = 64'hA0; we = 2'b01;
    sample();
    check("zero same cycle", rdU0[0], 64'h0);
    check("reset clears reg0", rdU0[1], 64'h0);
    nextCycle();
    we = '0;
    sample();
    check("zero after edge", rdU0[0], 64'h0);
    nextCycle();

    // Distinct pattern in registers 0..30, read back as neighbouring pairs.
    for (int i = 0; i <= 30; i++) begin
      wa[0] = 5'(i); wd[0] = 64'(i) * K; we = 2'b01;
      nextCycle();
    end
    we = '0;
    check("model pin pattern", mRead(0, 5'd5), 64'h0000050A14280005);
    for (int i = 1; i <= 30; i++) begin
      ra[0] = 5'(i - 1); ra[1] = 5'(i);
      sample();
      check($sformatf("pattern rd0 r%0d", i - 1), rdU0[0], 64'(i - 1) * K);
      check($sformatf("pattern rd1 r%0d", i), rdU0[1], 64'(i) * K);
      nextCycle();
    end

    // Forwarding versus pre-edge value.
    wa[0] = 5'd30; wd[0] = 64'hDEAD; we = 2'b01;
    nextCycle();
    wd[0] = 64'h5; ra[0] = 5'd30;
    sample();
    check("bypass same cycle", rdU0[0], 64'h5);
    check("nobypass old value", rdU1[0], 64'hDEAD);
    nextCycle();
    we = '0;
    sample();
    check("nobypass after edge", rdU1[0], 64'h5);
    nextCycle();

    // Write-port collision: port 1 wins.
    wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 64'h11; wd[1] = 64'h22; we = 2'b11; ra[0] = 5'd7;
    sample();
    check("collision bypass", rdU2[0], 64'h22);
    check("collision pre-edge", rdU1[0], 64'h7 * K);
    nextCycle();
    we = '0;
    sample();
    check("collision nobyp after", rdU1[0], 64'h22);
    check("collision byp after", rdU2[0], 64'h22);
    check("single port write", rdU0[0], 64'h11);
    check("model pin collision", mRead(1, 5'd7), 64'h22);
    nextCycle();

    // Mid-run reset discards the concurrent write.
    rst = 1'b1; wa[0] = 5'd3; wd[0] = 64'hFF; we = 2'b01; ra[0] = 5'd3;
    nextCycle();
    rst = 1'b0; we = '0;
    for (int a = 0; a < 16; a++) begin
      ra[0] = 5'(2 * a); ra[1] = 5'(2 * a + 1);
      sample();
      check($sformatf("reset r%0d", 2 * a), rdU0[0], 64'h0);
      check($sformatf("reset r%0d", 2 * a + 1), rdU0[1], 64'h0);
      check($sformatf("reset nwr r%0d", 2 * a), rdU1[0], 64'h0);
      nextCycle();
    end

    // Top register is ordinary storage when the zero register is disabled.
    wa[0] = 5'd15; wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; we = 2'b01;
    ra[0] = 5'd15; ra[1] = 5'd15; ra[2] = 5'd15;
    nextCycle();
    we = '0;
    sample();
    for (int p = 0; p < 3; p++)
      check($sformatf("small cfg rd%0d", p), {32'h0, rdU3[p]}, 64'hFFFF_FFFF);
    nextCycle();

    // Randomised traffic biased toward high addresses for collisions/bypass.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      we  = 2'($urandom);
      for (int p = 0; p < 3; p++)
        ra[p] = $urandom_range(0, 1) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 31));
      for (int w = 0; w < 2; w++) begin
        wa[w] = $urandom_range(0, 1) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 31));
        wd[w] = {$urandom(), $urandom()};
      end
      nextCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
